alu_dispatch: RTL and testbench

//   Register-register ALU dispatch unit for the rv32i core.

---
 rtl/alu_dispatch_if.sv | 43 ++++
 rtl/alu_dispatch.sv | 153 +++++++++++++++
 tb/tb_alu_dispatch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - request/response/unit-control bundle for the ALU dispatcher
//
// Purpose: groups the decode-side request handshake, the execution-unit
// enable/done lines and the response handshake into one interface.
// Modports:
//   master : decode stage, execution units and response consumer
//            (drives req_*, unit_done, rsp_ready)
//   slave  : the dispatcher itself
//            (drives req_ready, unit_enable, rsp_*, busy)
// Signals:
//   req_valid/req_ready, req_funct7[6:0], req_funct3[2:0], req_tag[TAG_W-1:0]
//   unit_enable[2:0] (one-hot BASE/EXTRA/MULDIV), unit_done[2:0]
//   rsp_valid/rsp_ready, rsp_tag[TAG_W-1:0], rsp_illegal, rsp_timeout, busy

interface alu_dispatch_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_funct7;
    logic [2:0]       req_funct3;
    logic [TAG_W-1:0] req_tag;

    logic [2:0]       unit_enable;
    logic [2:0]       unit_done;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_illegal;
    logic             rsp_timeout;
    logic             busy;

    modport master (
        output req_valid, req_funct7, req_funct3, req_tag, unit_done, rsp_ready,
        input  req_ready, unit_enable, rsp_valid, rsp_tag, rsp_illegal, rsp_timeout, busy
    );

    modport slave (
        input  req_valid, req_funct7, req_funct3, req_tag, unit_done, rsp_ready,
        output req_ready, unit_enable, rsp_valid, rsp_tag, rsp_illegal, rsp_timeout, busy
    );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - R-type ALU dispatch unit with legality check and timeout
//
// Purpose: accepts one decoded R-type op per handshake, checks funct7/funct3
// legality, raises a registered one-hot enable to the selected execution unit
// until it reports done (or a timeout expires), then returns a tagged
// response carrying illegal/timeout status.
// Optional feature macro: ALU_DISPATCH_MULDIV_EN (funct7=7'h01 -> MULDIV unit).
// Ports:
//   i_clock  in   rising-edge clock
//   i_reset  in   synchronous active-high reset
//   bus      slave modport of alu_dispatch_if (request, unit control, response)
// Parameters:
//   TAG_W           tag width (must match the interface)
//   TIMEOUT_CYCLES  max WAIT cycles before a forced timeout response (>=1)
//   CNT_W           counter width, 2**CNT_W > TIMEOUT_CYCLES

module alu_dispatch #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic          i_clock,
    input  logic          i_reset,
    alu_dispatch_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [2:0]       r_unit_enable;
    logic             r_rsp_valid;
    logic             r_rsp_illegal;
    logic             r_rsp_timeout;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [CNT_W-1:0] r_cnt;

    logic             w_legal;
    logic [2:0]       w_sel;
    logic             w_done;

    // Decode funct7/funct3 into a one-hot unit select; illegal encodings
    // leave w_sel at zero.
    always_comb begin
        w_legal = 1'b0;
        w_sel   = 3'b000;
        case (bus.req_funct7)
            7'h00: begin
                w_legal = 1'b1;
                w_sel   = 3'b001;
            end
            7'h20: begin
                // Only SUB and SRA have an alternate-encoding form.
                if (bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b101) begin
                    w_legal = 1'b1;
                    w_sel   = 3'b010;
                end
            end
`ifdef ALU_DISPATCH_MULDIV_EN
            7'h01: begin
                w_legal = 1'b1;
                w_sel   = 3'b100;
            end
`endif
            default: begin
                w_legal = 1'b0;
                w_sel   = 3'b000;
            end
        endcase
    end

    // Masking with the held enable observes only the selected unit's done bit;
    // with MULDIV disabled enable[2] is never set, so done[2] is ignored.
    assign w_done = |(bus.unit_done & r_unit_enable);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_unit_enable <= 3'b000;
            r_rsp_valid   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_tag     <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.req_valid) begin
                        r_rsp_tag <= bus.req_tag;
                        if (w_legal) begin
                            r_state       <= S_WAIT;
                            r_unit_enable <= w_sel;
                        end else begin
                            r_state       <= S_RESP;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_illegal <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // Done is checked before the timeout so a completion in
                    // the final allowed cycle still reports success.
                    if (w_done) begin
                        r_state       <= S_RESP;
                        r_unit_enable <= 3'b000;
                        r_rsp_valid   <= 1'b1;
                        r_cnt         <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state       <= S_RESP;
                        r_unit_enable <= 3'b000;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_cnt <= '0;
                    if (bus.rsp_ready) begin
                        r_state       <= S_IDLE;
                        r_rsp_valid   <= 1'b0;
                        r_rsp_illegal <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_unit_enable <= 3'b000;
                    r_rsp_valid   <= 1'b0;
                    r_rsp_illegal <= 1'b0;
                    r_rsp_timeout <= 1'b0;
                    r_cnt         <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.unit_enable = r_unit_enable;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_illegal = r_rsp_illegal;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.rsp_tag     = r_rsp_tag;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - self-checking bench for alu_dispatch

module tb_alu_dispatch;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
`ifdef ALU_DISPATCH_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_dispatch_if #(.TAG_W(TAG_W)) bus ();

    alu_dispatch #(
        .TAG_W(TAG_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(7)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] tag;
        int         done_after;  // WAIT cycle in which done is pulsed; 0 = never
        int         hold;        // cycles rsp_ready is held low in RESP
        logic [2:0] exp_en;
        bit         exp_ill;
        bit         exp_to;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the legality rules.
    function automatic logic [2:0] ref_sel(input logic [6:0] f7, input logic [2:0] f3);
        bit is_base, is_extra, is_md;
        is_base  = (f7 == 7'h00);
        is_extra = (f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5);
        is_md    = MULDIV && (f7 == 7'h01);
        return {is_md, is_extra, is_base};
    endfunction

    task automatic accept(input logic [6:0] f7, input logic [2:0] f3, input logic [3:0] tag);
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_funct7 = f7;
        bus.req_funct3 = f3;
        bus.req_tag    = tag;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        int k;
        int exp_k;
        bit got;
        bit stable;
        logic [2:0] noise;
        accept(v.f7, v.f3, v.tag);
        if (v.exp_ill) begin
            check("illegal_rsp_valid_1cyc", 32'(bus.rsp_valid), 32'd1);
        end else begin
            check("issue_enable", 32'(bus.unit_enable), 32'(v.exp_en));
            k = 0;
            got = 1'b0;
            stable = 1'b1;
            while (!got && k < TIMEOUT + 8) begin
                k++;
                if (bus.unit_enable !== v.exp_en) stable = 1'b0;
                noise = 3'($urandom) & ~v.exp_en;
                bus.unit_done = noise | ((k == v.done_after) ? v.exp_en : 3'b000);
                @(posedge clk);
                @(negedge clk);
                bus.unit_done = 3'b000;
                got = bus.rsp_valid;
            end
            exp_k = (v.done_after >= 1 && v.done_after <= TIMEOUT) ? v.done_after : TIMEOUT;
            check("rsp_seen", 32'(got), 32'd1);
            check("wait_cycles", 32'(k), 32'(exp_k));
            check("enable_held", 32'(stable), 32'd1);
        end
        check("rsp_enable_clear", 32'(bus.unit_enable), 32'd0);
        check("rsp_illegal", 32'(bus.rsp_illegal), 32'(v.exp_ill));
        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
        check("rsp_tag", 32'(bus.rsp_tag), 32'(v.tag));
        check("rsp_busy", 32'(bus.busy), 32'd1);
        stable = 1'b1;
        repeat (v.hold) begin
            bus.req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (!bus.rsp_valid || bus.req_ready || bus.rsp_tag !== v.tag ||
                bus.rsp_illegal !== v.exp_ill || bus.rsp_timeout !== v.exp_to)
                stable = 1'b0;
        end
        bus.req_valid = 1'b0;
        if (v.hold > 0) check("resp_backpressure_hold", 32'(stable), 32'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_status", 32'({bus.rsp_illegal, bus.rsp_timeout}), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_funct7 = 7'h00;
        bus.req_funct3 = 3'd0;
        bus.req_tag    = '0;
        bus.unit_done  = 3'b000;
        bus.rsp_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_enable", 32'(bus.unit_enable), 32'd0);
        check("reset_rsp", 32'({bus.rsp_valid, bus.rsp_illegal, bus.rsp_timeout}), 32'd0);
        check("reset_tag", 32'(bus.rsp_tag), 32'd0);
        check("reset_ready_busy", 32'({bus.req_ready, bus.busy}), 32'b10);

        //             f7     f3    tag  done hold  en      ill   to
        tbl.push_back('{7'h00, 3'd0, 4'd3,  2, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{7'h20, 3'd5, 4'd4,  1, 0, 3'b010, 1'b0, 1'b0});
        tbl.push_back('{7'h20, 3'd0, 4'd5,  3, 2, 3'b010, 1'b0, 1'b0});
        tbl.push_back('{7'h20, 3'd1, 4'd6,  0, 0, 3'b000, 1'b1, 1'b0});
        tbl.push_back('{7'h7F, 3'd0, 4'd7,  0, 1, 3'b000, 1'b1, 1'b0});
        tbl.push_back('{7'h00, 3'd7, 4'd8,  0, 0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{7'h00, 3'd2, 4'd9, 64, 1, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{7'h00, 3'd1, 4'd10, 1, 5, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{7'h01, 3'd4, 4'd11, 2, 0, (MULDIV ? 3'b100 : 3'b000), !MULDIV, 1'b0});
        tbl.push_back('{7'h20, 3'd7, 4'd12, 0, 0, 3'b000, 1'b1, 1'b0});
        tbl.push_back('{7'h40, 3'd0, 4'd13, 0, 0, 3'b000, 1'b1, 1'b0});
        tbl.push_back('{7'h00, 3'd4, 4'd14, 63, 0, 3'b001, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) do_op(tbl[i]);

        // Reset while in WAIT: enable drops at that edge, next op is clean.
        accept(7'h00, 3'd3, 4'd5);
        check("wait_enable_before_reset", 32'(bus.unit_enable), 32'd1);
        repeat (2) @(negedge clk);
        pulse_reset();
        check("wait_reset_enable", 32'(bus.unit_enable), 32'd0);
        check("wait_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("wait_reset_req_ready", 32'(bus.req_ready), 32'd1);
        do_op('{7'h00, 3'd6, 4'd2, 2, 0, 3'b001, 1'b0, 1'b0});

        // Reset while in RESP: pending response is discarded.
        accept(7'h7F, 3'd0, 4'd9);
        check("resp_before_reset", 32'(bus.rsp_valid), 32'd1);
        pulse_reset();
        check("resp_reset_enable", 32'(bus.unit_enable), 32'd0);
        check("resp_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("resp_reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("resp_reset_status", 32'({bus.rsp_illegal, bus.rsp_timeout}), 32'd0);
        do_op('{7'h20, 3'd5, 4'd1, 1, 0, 3'b010, 1'b0, 1'b0});

        // Randomized ops against the reference decode.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       rv.f7 = 7'h00;
                1:       rv.f7 = 7'h20;
                2:       rv.f7 = 7'h01;
                default: rv.f7 = 7'($urandom);
            endcase
            rv.f3         = 3'($urandom);
            rv.tag        = 4'($urandom);
            rv.done_after = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            rv.hold       = int'($urandom_range(0, 3));
            rv.exp_en     = ref_sel(rv.f7, rv.f3);
            rv.exp_ill    = (rv.exp_en == 3'b000);
            rv.exp_to     = !rv.exp_ill && (rv.done_after == 0);
            do_op(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1);
    end

endmodule
